// File: rtl/fb_pkg.sv
// Constants shared by the framebuffer write and read paths: source geometry,
// address width and RGB565 pixel format.
package fb_pkg;
  localparam int FB_H_PIXELS = 320;
  localparam int FB_V_LINES  = 240;
  localparam int FB_ADDR_W   = 18;
  localparam int FB_RGB_W    = 16;
  localparam logic [FB_RGB_W-1:0] FB_BLACK = 16'h0000;
endpackage

// File: rtl/fb_read_pipe.sv
// Return path for framebuffer reads: delays the request flags to meet the RAM
// data, then registers the pixel, substituting black for out-of-range slots.
module fb_read_pipe
  import fb_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_vld,
  input  logic                i_inrange,
  input  logic [FB_RGB_W-1:0] i_read_data,
  output logic [FB_RGB_W-1:0] o_rgb565,
  output logic                o_rgb565_valid
);

  logic [RD_LATENCY:0] vld_sr;
  logic [RD_LATENCY:0] inr_sr;
  logic [FB_RGB_W-1:0] rgb_p2;
  logic                vld_p2;

  // p0 -> p1: request flags travel RD_LATENCY+1 cycles to align with RAM data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_sr <= '0;
      inr_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[RD_LATENCY-1:0], i_vld};
      inr_sr <= {inr_sr[RD_LATENCY-1:0], i_inrange};
    end
  end

  // p1 -> p2: output register; pixel holds while no slot is valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p2 <= 1'b0;
      rgb_p2 <= FB_BLACK;
    end else begin
      vld_p2 <= vld_sr[RD_LATENCY];
      if (vld_sr[RD_LATENCY]) begin
        rgb_p2 <= inr_sr[RD_LATENCY] ? i_read_data : FB_BLACK;
      end
    end
  end

  assign o_rgb565       = rgb_p2;
  assign o_rgb565_valid = vld_p2;

endmodule

// File: rtl/framebuffer_reader.sv
// Maps DVI pixel requests onto framebuffer read addresses and returns RGB565
// pixels in order. FRAMEBUFFER_READER_SCALE2X_EN selects 2x pixel/line repeat.
module framebuffer_reader
  import fb_pkg::*;
#(
  parameter int H_PIXELS   = FB_H_PIXELS,
  parameter int V_LINES    = FB_V_LINES,
  parameter int RD_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_start,
  input  logic                 i_line_start,
  input  logic                 i_pixel_req,
  output logic [FB_ADDR_W-1:0] o_read_address,
  output logic                 o_read_enable,
  input  logic [FB_RGB_W-1:0]  i_read_data,
  output logic [FB_RGB_W-1:0]  o_rgb565,
  output logic                 o_rgb565_valid,
  output logic                 o_range_err
);

  localparam int X_W = $clog2(H_PIXELS + 1);
  localparam int L_W = $clog2(2 * V_LINES + 1);
  localparam logic [X_W-1:0]       X_END     = X_W'(H_PIXELS);
  localparam logic [L_W-1:0]       L_END     = L_W'(V_LINES);
  localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(H_PIXELS);

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (v == X_END) ? v : v + 1'b1;
  endfunction

  function automatic logic [L_W-1:0] sat_inc_line(input logic [L_W-1:0] v);
    return (v == {L_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [L_W-1:0]       out_line_q, out_line_d;
  logic [X_W-1:0]       src_x_q, src_x_d;
  logic [FB_ADDR_W-1:0] line_base_q, line_base_d;
  logic                 line_open_q, line_open_d;
  logic                 first_pend_q, first_pend_d;
  logic                 err_q, err_d;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
  logic                 x_phase_q, x_phase_d;
`endif

  logic [L_W-1:0]       src_line_p0;
  logic                 vld_p0;
  logic                 inrange_p0;
  logic [FB_ADDR_W-1:0] addr_p0;
  logic                 rd_en_p1;
  logic [FB_ADDR_W-1:0] rd_addr_p1;

  // p0: frame_start, then line_start, then the request on updated counters
  always_comb begin
    out_line_d   = out_line_q;
    src_x_d      = src_x_q;
    line_base_d  = line_base_q;
    line_open_d  = line_open_q;
    first_pend_d = first_pend_q;
    err_d        = err_q;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
    x_phase_d    = x_phase_q;
`endif

    if (i_frame_start) begin
      out_line_d   = '0;
      line_base_d  = '0;
      line_open_d  = 1'b0;
      first_pend_d = 1'b1;
      err_d        = 1'b0;
    end

    if (i_line_start) begin
      src_x_d     = '0;
      line_open_d = 1'b1;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
      x_phase_d   = 1'b0;
`endif
      if (!first_pend_d) begin
        out_line_d = sat_inc_line(out_line_d);
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
        if (!out_line_d[0] && ((out_line_d >> 1) < L_END)) begin
`else
        if (out_line_d < L_END) begin
`endif
          line_base_d = line_base_d + LINE_STEP;
        end
      end
      first_pend_d = 1'b0;
    end

`ifdef FRAMEBUFFER_READER_SCALE2X_EN
    src_line_p0 = out_line_d >> 1;
`else
    src_line_p0 = out_line_d;
`endif
    vld_p0     = i_pixel_req;
    inrange_p0 = i_pixel_req && line_open_d && (src_x_d < X_END) && (src_line_p0 < L_END);
    addr_p0    = line_base_d + FB_ADDR_W'(src_x_d);

    if (i_pixel_req) begin
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
      if (x_phase_d) begin
        src_x_d = sat_inc_x(src_x_d);
      end
      x_phase_d = ~x_phase_d;
`else
      src_x_d = sat_inc_x(src_x_d);
`endif
      if (!inrange_p0) begin
        err_d = 1'b1;
      end
    end
  end

  // p0 -> p1: counter state and RAM read strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_line_q   <= '0;
      src_x_q      <= '0;
      line_base_q  <= '0;
      line_open_q  <= 1'b0;
      first_pend_q <= 1'b1;
      err_q        <= 1'b0;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
      x_phase_q    <= 1'b0;
`endif
      rd_en_p1     <= 1'b0;
      rd_addr_p1   <= '0;
    end else begin
      out_line_q   <= out_line_d;
      src_x_q      <= src_x_d;
      line_base_q  <= line_base_d;
      line_open_q  <= line_open_d;
      first_pend_q <= first_pend_d;
      err_q        <= err_d;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
      x_phase_q    <= x_phase_d;
`endif
      rd_en_p1     <= inrange_p0;
      if (inrange_p0) begin
        rd_addr_p1 <= addr_p0;
      end
    end
  end

  assign o_read_enable  = rd_en_p1;
  assign o_read_address = rd_addr_p1;
  assign o_range_err    = err_q;

  fb_read_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_pipe (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_vld         (vld_p0),
    .i_inrange     (inrange_p0),
    .i_read_data   (i_read_data),
    .o_rgb565      (o_rgb565),
    .o_rgb565_valid(o_rgb565_valid)
  );

endmodule

// File: tb/tb_framebuffer_reader.sv
// Directed bench for framebuffer_reader with a RAM model returning 0xA000+addr.
module tb_framebuffer_reader;
  localparam int RD_LAT = 2;
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pixel_req = 1'b0;
  logic [17:0] read_address;
  logic        read_enable;
  logic [15:0] read_data;
  logic [15:0] rgb565;
  logic        rgb565_valid;
  logic        range_err;

  int checks = 0;
  int failures = 0;

  framebuffer_reader #(.H_PIXELS(320), .V_LINES(240), .RD_LATENCY(RD_LAT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (frame_start),
    .i_line_start  (line_start),
    .i_pixel_req   (pixel_req),
    .o_read_address(read_address),
    .o_read_enable (read_enable),
    .i_read_data   (read_data),
    .o_rgb565      (rgb565),
    .o_rgb565_valid(rgb565_valid),
    .o_range_err   (range_err)
  );

  always #5 clk = ~clk;

  logic [RD_LAT-1:0]       en_d = '0;
  logic [RD_LAT-1:0][17:0] addr_d = '0;
  always @(posedge clk) begin
    en_d[0]   <= read_enable;
    addr_d[0] <= read_address;
    for (int i = 1; i < RD_LAT; i++) begin
      en_d[i]   <= en_d[i-1];
      addr_d[i] <= addr_d[i-1];
    end
  end
  assign read_data = en_d[RD_LAT-1] ? 16'hA000 + addr_d[RD_LAT-1][15:0] : 16'hDEAD;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int n);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      line_start = 1'b1;
      tick();
    end
    line_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks += 5;
    if (read_address !== 18'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", read_address); end
    if (read_enable !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", read_enable); end
    if (rgb565 !== 16'h0000) begin failures++; $display("FAIL reset_rgb got=%h exp=0000", rgb565); end
    if (rgb565_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", rgb565_valid); end
    if (range_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", range_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int j;
    logic [17:0] ea;
    logic [15:0] last;
    start_line(1);
    last = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      pixel_req = (k < 3);
      tick();
      checks++;
      if (read_enable !== (k < 3)) begin failures++; $display("FAIL basic_en k=%0d got=%b", k, read_enable); end
      if (k < 3) begin
        ea = SCALE ? 18'(k >> 1) : 18'(k);
        checks++;
        if (read_address !== ea) begin failures++; $display("FAIL basic_addr k=%0d got=%0d exp=%0d", k, read_address, ea); end
      end
      j = k - 3;
      checks++;
      if (rgb565_valid !== (j >= 0 && j < 3)) begin failures++; $display("FAIL basic_vld k=%0d got=%b", k, rgb565_valid); end
      if (j >= 0 && j < 3) begin
        last = 16'hA000 + (SCALE ? 16'(j >> 1) : 16'(j));
        checks++;
        if (rgb565 !== last) begin failures++; $display("FAIL basic_rgb k=%0d got=%h exp=%h", k, rgb565, last); end
      end else if (k >= 6) begin
        checks++;
        if (rgb565 !== last) begin failures++; $display("FAIL basic_hold k=%0d got=%h exp=%h", k, rgb565, last); end
      end
    end
    pixel_req = 1'b0;
  endtask

  task automatic test_third_line;
    logic [17:0] ea;
    ea = SCALE ? 18'd320 : 18'd640;
    start_line(3);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    checks += 2;
    if (read_enable !== 1'b1) begin failures++; $display("FAIL line3_en got=%b exp=1", read_enable); end
    if (read_address !== ea) begin failures++; $display("FAIL line3_addr got=%0d exp=%0d", read_address, ea); end
    tick(); tick(); tick();
    checks += 2;
    if (rgb565_valid !== 1'b1) begin failures++; $display("FAIL line3_vld got=%b exp=1", rgb565_valid); end
    if (rgb565 !== 16'hA000 + ea[15:0]) begin failures++; $display("FAIL line3_rgb got=%h exp=%h", rgb565, 16'hA000 + ea[15:0]); end
  endtask

  task automatic test_overrun;
    int j;
    int reads;
    logic [15:0] er;
    reads = 0;
    start_line(1);
    for (int k = 0; k < 325; k++) begin
      pixel_req = (k < 321);
      tick();
      if (read_enable === 1'b1) reads++;
      checks += 2;
      if (read_enable !== (k < 320)) begin failures++; $display("FAIL ovr_en k=%0d got=%b", k, read_enable); end
      if (range_err !== (k >= 320)) begin failures++; $display("FAIL ovr_err k=%0d got=%b", k, range_err); end
      if (k < 320) begin
        checks++;
        if (read_address !== 18'(k)) begin failures++; $display("FAIL ovr_addr k=%0d got=%0d", k, read_address); end
      end
      j = k - 3;
      checks++;
      if (rgb565_valid !== (j >= 0 && j <= 320)) begin failures++; $display("FAIL ovr_vld k=%0d got=%b", k, rgb565_valid); end
      if (j >= 0 && j <= 320) begin
        er = (j < 320) ? 16'hA000 + 16'(j) : 16'h0000;
        checks++;
        if (rgb565 !== er) begin failures++; $display("FAIL ovr_rgb j=%0d got=%h exp=%h", j, rgb565, er); end
      end
    end
    pixel_req = 1'b0;
    checks++;
    if (reads != 320) begin failures++; $display("FAIL ovr_reads got=%0d exp=320", reads); end
    tick(); tick();
    checks++;
    if (range_err !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", range_err); end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (range_err !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", range_err); end
  endtask

  task automatic test_frame_start_req;
    frame_start = 1'b1;
    pixel_req = 1'b1;
    tick();
    frame_start = 1'b0;
    pixel_req = 1'b0;
    checks += 2;
    if (read_enable !== 1'b0) begin failures++; $display("FAIL fsreq_en got=%b exp=0", read_enable); end
    if (range_err !== 1'b1) begin failures++; $display("FAIL fsreq_err got=%b exp=1", range_err); end
    tick(); tick(); tick();
    checks += 3;
    if (rgb565_valid !== 1'b1) begin failures++; $display("FAIL fsreq_vld got=%b exp=1", rgb565_valid); end
    if (rgb565 !== 16'h0000) begin failures++; $display("FAIL fsreq_rgb got=%h exp=0000", rgb565); end
    if (range_err !== 1'b1) begin failures++; $display("FAIL fsreq_sticky got=%b exp=1", range_err); end
    frame_start = 1'b1;
    line_start = 1'b1;
    pixel_req = 1'b1;
    tick();
    frame_start = 1'b0;
    line_start = 1'b0;
    pixel_req = 1'b0;
    checks += 3;
    if (read_enable !== 1'b1) begin failures++; $display("FAIL fsls_en got=%b exp=1", read_enable); end
    if (read_address !== 18'd0) begin failures++; $display("FAIL fsls_addr got=%0d exp=0", read_address); end
    if (range_err !== 1'b0) begin failures++; $display("FAIL fsls_err got=%b exp=0", range_err); end
    tick(); tick(); tick();
    checks += 2;
    if (rgb565_valid !== 1'b1) begin failures++; $display("FAIL fsls_vld got=%b exp=1", rgb565_valid); end
    if (rgb565 !== 16'hA000) begin failures++; $display("FAIL fsls_rgb got=%h exp=a000", rgb565); end
  endtask

  task automatic test_2x_line3;
    logic [17:0] ea;
    logic [15:0] er;
    start_line(4);
    for (int k = 0; k < 8; k++) begin
      pixel_req = (k < 4);
      tick();
      checks++;
      if (read_enable !== (k < 4)) begin failures++; $display("FAIL x2_en k=%0d got=%b", k, read_enable); end
      if (k < 4) begin
        ea = 18'd320 + 18'(k >> 1);
        checks++;
        if (read_address !== ea) begin failures++; $display("FAIL x2_addr k=%0d got=%0d exp=%0d", k, read_address, ea); end
      end
      if (k >= 3) begin
        er = 16'hA140 + 16'((k - 3) >> 1);
        checks += 2;
        if (rgb565_valid !== 1'b1) begin failures++; $display("FAIL x2_vld k=%0d got=%b", k, rgb565_valid); end
        if (rgb565 !== er) begin failures++; $display("FAIL x2_rgb k=%0d got=%h exp=%h", k, rgb565, er); end
      end
    end
    pixel_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    start_line(1);
    for (int k = 0; k < 3; k++) begin
      pixel_req = 1'b1;
      tick();
    end
    pixel_req = 1'b0;
    rst = 1'b1;
    tick();
    checks += 5;
    if (read_address !== 18'd0) begin failures++; $display("FAIL rmid_addr got=%0d exp=0", read_address); end
    if (read_enable !== 1'b0) begin failures++; $display("FAIL rmid_en got=%b exp=0", read_enable); end
    if (rgb565 !== 16'h0000) begin failures++; $display("FAIL rmid_rgb got=%h exp=0000", rgb565); end
    if (rgb565_valid !== 1'b0) begin failures++; $display("FAIL rmid_vld got=%b exp=0", rgb565_valid); end
    if (range_err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", range_err); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks += 2;
      if (rgb565_valid !== 1'b0) begin failures++; $display("FAIL rmid_flush k=%0d got=%b exp=0", k, rgb565_valid); end
      if (rgb565 !== 16'h0000) begin failures++; $display("FAIL rmid_hold k=%0d got=%h exp=0000", k, rgb565); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_third_line();
`ifdef FRAMEBUFFER_READER_SCALE2X_EN
    test_2x_line3();
`else
    test_overrun();
`endif
    test_frame_start_req();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/framebuffer_reader.md
# framebuffer_reader

Read-side counterpart of the LCD framebuffer write path: converts the DVI timing generator's per-pixel requests into framebuffer read addresses and returns RGB565 pixels in request order. The block sits between the dual-port framebuffer RAM read port and the DVI encoder. It covers the 320x240 source image and can optionally 2x-upscale it to 640x480 DVI.

## Interface
- H_PIXELS, 320, source pixels per line
- V_LINES, 240, source lines per frame
- RD_LATENCY, 2, RAM read latency in cycles from o_read_enable to valid i_read_data (1..4)
- i_clk  in  1  pixel clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_frame_start  in  1  single-cycle pulse before the first active line of a frame
- i_line_start  in  1  single-cycle pulse before each active line
- i_pixel_req  in  1  one pixel requested this cycle (DVI data-enable)
- o_read_address  out  18  framebuffer read address
- o_read_enable  out  1  read strobe to RAM
- i_read_data  in  16  RAM read data, RD_LATENCY cycles after o_read_enable
- o_rgb565  out  16  pixel to DVI encoder
- o_rgb565_valid  out  1  o_rgb565 holds a pixel this cycle
- o_range_err  out  1  sticky: a request fell outside the source image; cleared by i_frame_start

## Operation
- Counters: out_line (output lines since frame start), src_x, x_phase, line_base (18 bit), line_open flag.
- i_frame_start: out_line=0, line_base=0, line_open=0, o_range_err=0.
- i_line_start: src_x=0, x_phase=0, line_open=1. Every i_line_start except the first after i_frame_start increments out_line. line_base advances by H_PIXELS when the source line changes: on every increment without scaling, and on increments to an even out_line with scaling.
- Source line = out_line (1:1) or out_line>>1 (2x).
- i_pixel_req in range (line_open, src_x<H_PIXELS, source line<V_LINES): next cycle o_read_enable=1, o_read_address=line_base+src_x. src_x then increments on every request (1:1), or on every second request, toggling x_phase (2x). With 2x, the same address is read twice.
- Out-of-range request: no read strobe. A black pixel (0x0000) is still emitted at the normal latency, and o_range_err is set.
- Every request yields exactly one output pixel, in order. No backpressure.
- Simultaneous events: i_frame_start is applied first, then i_line_start, then i_pixel_req using the updated counters. A request coinciding with i_frame_start alone is out of range (line_open=0).
- Address arithmetic is 18-bit unsigned. line_base never exceeds (V_LINES-1)*H_PIXELS, so it does not wrap.

## Timing
- i_pixel_req at cycle N: o_read_enable/o_read_address at N+1, RAM data at N+1+RD_LATENCY, o_rgb565_valid/o_rgb565 at N+2+RD_LATENCY (4 cycles at default).
- Back-to-back requests produce back-to-back outputs.
- Reset values: o_read_address=0, o_read_enable=0, o_rgb565=0x0000, o_rgb565_valid=0, o_range_err=0. All counters are 0 and line_open=0.
- Reset mid-line flushes the pipeline; no valid output appears after the cycle following reset assertion.
- o_rgb565 holds its last value while o_rgb565_valid=0.

## Configuration
- FRAMEBUFFER_READER_SCALE2X_EN defined: 2x horizontal pixel repeat and 2x line repeat, so 640x480 output covers the 320x240 source.
- Not defined: 1:1 mapping. x_phase logic is absent, and requests beyond 320x240 return black and set o_range_err.

## Structure
- Shared package fb_pkg holds:
  - FB_H_PIXELS=320, FB_V_LINES=240, FB_ADDR_W=18
  - RGB565 width constant and black constant 16'h0000
  - These constants are shared with the write path.
- One sub-module, fb_read_pipe: a RD_LATENCY+1 deep shift register. It carries valid and in-range flags, registers i_read_data, and muxes in black for out-of-range slots.

## Test plan
- Reset, then frame_start, line_start, 3 consecutive requests, RAM model with words 0xA000+addr, 1:1 mode -> reads at addresses 0,1,2; outputs 0xA000, 0xA001, 0xA002 with valid asserted exactly 4 cycles after each request.
- 1:1 mode, third line_start after frame_start, request -> address 640 (2*320).
- 2x mode, 4 requests on out_line 3 -> addresses 320,320,321,321; outputs duplicated pairs.
- 1:1 mode, 321 requests in one line -> 320 reads; 321st output 0x0000; o_range_err=1 until next frame_start.
- Request on the same cycle as frame_start without line_start -> no read, black output, o_range_err=1. Simultaneous frame_start+line_start+request -> address 0.
- Reset asserted 1 cycle after a request burst -> no o_rgb565_valid afterwards; all outputs at reset values.
